order_book_driver: RTL and testbench
====================================

Name: order_book_driver

Overview:
- Initiator side of the order-book request handshake (start_book / request / is_busy).
- Accepts decoded order commands from the feed parser on a valid/ready stream and issues them one at a time to an order book.
- Waits for each command to complete, then returns a single-cycle completion record with the book's post-operation price, size and cancel update.
- Adds a watchdog and per-outcome counters; one instance per book side.

Parameters:
- PRICE_W, 12, price field width
- QTY_W, 16, quantity field width
- ID_W, 10, order id width
- SIZE_W, 10, book size width
- UPD_W, 3, cancel_update width
- REQ_ADD, 3'd1, add request code
- REQ_CANCEL, 3'd2, cancel request code
- REQ_EXECUTE, 3'd3, execute request code
- TIMEOUT, 1023, max cycles spent in each wait state before error
- CNT_W, 16, counter width

Ports:
- clk_in  in  1  clock
- rst_in_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_req  in  3  request code
- cmd_id  in  ID_W  order id (cancel/execute)
- cmd_qty  in  QTY_W  quantity (add/execute)
- cmd_order  in  ID_W+QTY_W+PRICE_W  packed order for add: {qty, id, price}, price in LSBs, qty in MSBs
- start_book  out  1  one-cycle issue strobe to the book
- request  out  3  request code to the book
- order_id  out  ID_W  to the book
- quantity  out  QTY_W  to the book
- order_to_add  out  ID_W+QTY_W+PRICE_W  to the book
- is_busy  in  1  book busy
- cancel_update  in  UPD_W  from the book
- best_price  in  PRICE_W  from the book
- best_price_valid  in  1  from the book
- size_book  in  SIZE_W  from the book
- rsp_valid  out  1  one-cycle completion strobe
- rsp_status  out  2  0 = OK, 1 = bad request code, 2 = timeout
- rsp_req  out  3  echoed request code
- rsp_price  out  PRICE_W  best price captured at completion
- rsp_price_valid  out  1  best_price_valid captured at completion
- rsp_size  out  SIZE_W  size captured at completion
- rsp_update  out  UPD_W  cancel_update captured at completion
- cnt_ok  out  CNT_W  completed commands
- cnt_err  out  CNT_W  bad-code plus timeout count

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs and counters are 0 except cmd_ready, which is 1 in IDLE.
- Reset mid-operation: abandons the command with no response and drops start_book immediately. The book's own reset is the system's responsibility.
- cmd_ready = (state == IDLE). A command is accepted when cmd_valid && cmd_ready and is latched into the command register.
- Book-side fields (request, order_id, quantity, order_to_add) are driven from the command register and stay stable from issue until response.
- IDLE, on accept:
  - Code not in {REQ_ADD, REQ_CANCEL, REQ_EXECUTE} -> RESP with status 1; nothing issued to the book.
  - Valid code and is_busy = 0 -> ISSUE.
  - Valid code and is_busy = 1 -> HOLD.
- HOLD: waits for is_busy = 0, then goes to ISSUE. The watchdog runs; on expiry -> RESP with status 2.
- ISSUE: start_book = 1 for exactly this cycle, then -> WAIT_HI.
- WAIT_HI: waits for is_busy = 1, which the book raises the cycle after start_book.
  - On is_busy = 1 -> WAIT_LO.
  - On watchdog expiry -> RESP with status 2.
- WAIT_LO: waits for is_busy = 0.
  - The cycle after is_busy falls, capture best_price, best_price_valid, size_book and cancel_update, because the book updates these on the same edge busy clears.
  - Then -> RESP with status 0.
  - Watchdog expiry -> RESP with status 2.
- RESP: rsp_valid = 1 for one cycle with the rsp_* fields, then -> IDLE. rsp_* fields hold their values until the next response.
  - Status 0 increments cnt_ok; any other status increments cnt_err.
  - Counters saturate at all-ones.
- Watchdog:
  - Counter cleared on entry to HOLD, WAIT_HI and WAIT_LO.
  - Expires when it reaches TIMEOUT.
  - TIMEOUT = 0 means expiry on the first wait cycle.
- Latency, idle book, for a book busy for B cycles: accept at cycle 0, start_book at 1, is_busy high at 2, low at 2+B, capture at 3+B, rsp_valid at 4+B.
- Back-to-back: the next command can be accepted the cycle after rsp_valid. start_book is never asserted while is_busy = 1 or outside ISSUE.
- cmd_* inputs are ignored when cmd_ready = 0.

Test Plan:
- Add, idle book (model busy 3 cycles), cmd_req = 1, cmd_order = {qty 100, id 5, price 0x064} -> start_book one pulse with order_to_add equal to the input; rsp_valid at cycle 7 with status 0, rsp_price 0x064, rsp_size 1; cnt_ok = 1.
- cmd_req = 3'd6 -> no start_book; rsp_valid the cycle after accept with status 1; cnt_err = 1.
- Cancel id 5 while the model holds is_busy = 1 for 10 cycles -> start_book is issued only after busy falls; cancel_update 3'b001 is returned in rsp_update.
- TIMEOUT = 20, model never raises is_busy after start_book -> rsp_valid 21 cycles after entering WAIT_HI with status 2; cmd_ready returns to 1.
- Four back-to-back commands with cmd_valid held high -> exactly four start_book pulses, none overlapping busy; four responses in order.
- Assert rst_in_n low during WAIT_LO -> outputs 0 immediately, no rsp_valid; after release, cmd_ready = 1 and counters = 0.

Source files
------------

// File: rtl/order_book_driver.sv
// Order-book request initiator: one command in flight, busy handshake, watchdog, outcome counters.
// Latency 4+B cycles accept-to-rsp_valid on an idle book; cmd_ready stays low until the cycle after rsp_valid.
module order_book_driver #(
  parameter int         PRICE_W     = 12,
  parameter int         QTY_W       = 16,
  parameter int         ID_W        = 10,
  parameter int         SIZE_W      = 10,
  parameter int         UPD_W       = 3,
  parameter logic [2:0] REQ_ADD     = 3'd1,
  parameter logic [2:0] REQ_CANCEL  = 3'd2,
  parameter logic [2:0] REQ_EXECUTE = 3'd3,
  parameter int         TIMEOUT     = 1023,
  parameter int         CNT_W       = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [2:0]                      cmd_req,
  input  logic [ID_W-1:0]                 cmd_id,
  input  logic [QTY_W-1:0]                cmd_qty,
  input  logic [ID_W+QTY_W+PRICE_W-1:0]   cmd_order,
  output logic                            start_book,
  output logic [2:0]                      request,
  output logic [ID_W-1:0]                 order_id,
  output logic [QTY_W-1:0]                quantity,
  output logic [ID_W+QTY_W+PRICE_W-1:0]   order_to_add,
  input  logic                            is_busy,
  input  logic [UPD_W-1:0]                cancel_update,
  input  logic [PRICE_W-1:0]              best_price,
  input  logic                            best_price_valid,
  input  logic [SIZE_W-1:0]               size_book,
  output logic                            rsp_valid,
  output logic [1:0]                      rsp_status,
  output logic [2:0]                      rsp_req,
  output logic [PRICE_W-1:0]              rsp_price,
  output logic                            rsp_price_valid,
  output logic [SIZE_W-1:0]               rsp_size,
  output logic [UPD_W-1:0]                rsp_update,
  output logic [CNT_W-1:0]                cnt_ok,
  output logic [CNT_W-1:0]                cnt_err
);

  localparam int ORD_W = ID_W + QTY_W + PRICE_W;
  localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BADCODE = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    CAPTURE,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0]       req;
    logic [ID_W-1:0]  id;
    logic [QTY_W-1:0] qty;
    logic [ORD_W-1:0] order;
  } cmd_t;

  typedef struct packed {
    logic [1:0]         status;
    logic [2:0]         req;
    logic [PRICE_W-1:0] price;
    logic               price_valid;
    logic [SIZE_W-1:0]  size;
    logic [UPD_W-1:0]   update;
  } rsp_t;

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  rsp_t              rsp_q, rsp_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]  cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0]  cnt_err_q, cnt_err_d;

  logic              code_ok;
  logic              wd_expired;
  logic              resp_go;
  logic [1:0]        resp_status;

  assign code_ok    = (cmd_req == REQ_ADD) || (cmd_req == REQ_CANCEL) || (cmd_req == REQ_EXECUTE);
  assign wd_expired = (wdog_q == WD_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    wdog_d      = wdog_q;
    cnt_ok_d    = cnt_ok_q;
    cnt_err_d   = cnt_err_q;
    resp_go     = 1'b0;
    resp_status = ST_OK;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.req   = cmd_req;
          cmd_d.id    = cmd_id;
          cmd_d.qty   = cmd_qty;
          cmd_d.order = cmd_order;
          if (!code_ok) begin
            resp_go     = 1'b1;
            resp_status = ST_BADCODE;
          end else if (is_busy) begin
            state_d = HOLD;
            wdog_d  = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      HOLD: begin
        if (!is_busy) begin
          state_d = ISSUE;
        end else if (wd_expired) begin
          resp_go     = 1'b1;
          resp_status = ST_TIMEOUT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
        wdog_d  = '0;
      end
      WAIT_HI: begin
        if (is_busy) begin
          state_d = WAIT_LO;
          wdog_d  = '0;
        end else if (wd_expired) begin
          resp_go     = 1'b1;
          resp_status = ST_TIMEOUT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      WAIT_LO: begin
        if (!is_busy) begin
          state_d = CAPTURE;
        end else if (wd_expired) begin
          resp_go     = 1'b1;
          resp_status = ST_TIMEOUT;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      // Book outputs settle on the edge busy clears; sample them one cycle later.
      CAPTURE: begin
        resp_go     = 1'b1;
        resp_status = ST_OK;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (resp_go) begin
      state_d       = RESP;
      rsp_d.status  = resp_status;
      rsp_d.req     = (state_q == IDLE) ? cmd_req : cmd_q.req;
      if (resp_status == ST_OK) begin
        rsp_d.price       = best_price;
        rsp_d.price_valid = best_price_valid;
        rsp_d.size        = size_book;
        rsp_d.update      = cancel_update;
        if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + CNT_W'(1);
      end else begin
        rsp_d.price       = '0;
        rsp_d.price_valid = 1'b0;
        rsp_d.size        = '0;
        rsp_d.update      = '0;
        if (cnt_err_q != '1) cnt_err_d = cnt_err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rsp_q     <= '0;
      wdog_q    <= '0;
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rsp_q     <= rsp_d;
      wdog_q    <= wdog_d;
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign start_book      = (state_q == ISSUE);
  assign request         = cmd_q.req;
  assign order_id        = cmd_q.id;
  assign quantity        = cmd_q.qty;
  assign order_to_add    = cmd_q.order;

  assign rsp_valid       = (state_q == RESP);
  assign rsp_status      = rsp_q.status;
  assign rsp_req         = rsp_q.req;
  assign rsp_price       = rsp_q.price;
  assign rsp_price_valid = rsp_q.price_valid;
  assign rsp_size        = rsp_q.size;
  assign rsp_update      = rsp_q.update;
  assign cnt_ok          = cnt_ok_q;
  assign cnt_err         = cnt_err_q;

endmodule

// File: tb/tb_order_book_driver.sv
// Directed bench for order_book_driver against a small behavioural order book.
// Inputs change and outputs are sampled 2 ns after the falling edge, i.e. mid-cycle.
module tb_order_book_driver;

  localparam int PRICE_W = 12;
  localparam int QTY_W   = 16;
  localparam int ID_W    = 10;
  localparam int SIZE_W  = 10;
  localparam int UPD_W   = 3;
  localparam int CNT_W   = 16;
  localparam int ORD_W   = ID_W + QTY_W + PRICE_W;

  logic                clk_in = 1'b0;
  logic                rst_in_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [2:0]          cmd_req = '0;
  logic [ID_W-1:0]     cmd_id = '0;
  logic [QTY_W-1:0]    cmd_qty = '0;
  logic [ORD_W-1:0]    cmd_order = '0;
  logic                start_book;
  logic [2:0]          request;
  logic [ID_W-1:0]     order_id;
  logic [QTY_W-1:0]    quantity;
  logic [ORD_W-1:0]    order_to_add;
  logic                is_busy = 1'b0;
  logic [UPD_W-1:0]    cancel_update = '0;
  logic [PRICE_W-1:0]  best_price = '0;
  logic                best_price_valid = 1'b0;
  logic [SIZE_W-1:0]   size_book = '0;
  logic                rsp_valid;
  logic [1:0]          rsp_status;
  logic [2:0]          rsp_req;
  logic [PRICE_W-1:0]  rsp_price;
  logic                rsp_price_valid;
  logic [SIZE_W-1:0]   rsp_size;
  logic [UPD_W-1:0]    rsp_update;
  logic [CNT_W-1:0]    cnt_ok;
  logic [CNT_W-1:0]    cnt_err;

  int n_cmp = 0;
  int n_bad = 0;

  order_book_driver #(.TIMEOUT(20)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_req(cmd_req), .cmd_id(cmd_id),
    .cmd_qty(cmd_qty), .cmd_order(cmd_order),
    .start_book(start_book), .request(request), .order_id(order_id), .quantity(quantity),
    .order_to_add(order_to_add), .is_busy(is_busy), .cancel_update(cancel_update),
    .best_price(best_price), .best_price_valid(best_price_valid), .size_book(size_book),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_req(rsp_req), .rsp_price(rsp_price),
    .rsp_price_valid(rsp_price_valid), .rsp_size(rsp_size), .rsp_update(rsp_update),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk_in = ~clk_in;

  // Book model: busy from the cycle after start_book for busy_len cycles; ext_seq bumps add foreign busy.
  int   busy_len = 3;
  bit   never_rise = 1'b0;
  int   ext_len = 0;
  int   ext_seq = 0;
  int   ext_seen = 0;
  int   ext_left = 0;
  int   op_left = 0;
  int   m_size = 0;
  bit   go = 1'b0;
  bit   ext_b = 1'b0;
  bit   op_b = 1'b0;
  logic [2:0]       m_req = '0;
  logic [ORD_W-1:0] m_ord = '0;

  always begin
    @(negedge clk_in);
    #1;
    if (!rst_in_n) begin
      go = 1'b0; op_left = 0; ext_left = 0; ext_b = 1'b0; op_b = 1'b0; m_size = 0;
      ext_seen = ext_seq; best_price = '0; best_price_valid = 1'b0; cancel_update = '0;
    end else begin
      if (ext_seq != ext_seen) begin
        ext_seen = ext_seq; ext_b = 1'b1; ext_left = ext_len;
      end else if (ext_left > 0) begin
        ext_left--;
        if (ext_left == 0) ext_b = 1'b0;
      end
      if (go) begin
        go = 1'b0;
        if (!never_rise) begin op_b = 1'b1; op_left = busy_len; end
      end else if (op_left > 0) begin
        op_left--;
        if (op_left == 0) begin
          op_b = 1'b0;
          if (m_req == 3'd1) begin
            if (!best_price_valid || m_ord[PRICE_W-1:0] > best_price) best_price = m_ord[PRICE_W-1:0];
            best_price_valid = 1'b1; m_size++; cancel_update = 3'b000;
          end else if (m_req == 3'd2) begin
            if (m_size > 0) m_size--;
            best_price_valid = (m_size != 0); cancel_update = 3'b001;
          end else begin
            cancel_update = 3'b010;
          end
        end
      end
      if (start_book) begin go = 1'b1; m_req = request; m_ord = order_to_add; end
    end
    size_book = SIZE_W'(m_size);
    is_busy = ext_b | op_b;
  end

  task automatic step;
    @(negedge clk_in);
    #2;
  endtask

  // Drives one command and watches until its response or 60 cycles; k counts cycles from accept.
  task automatic run_cmd(input logic [2:0] req, input logic [ID_W-1:0] id, input logic [QTY_W-1:0] qty,
                         input logic [ORD_W-1:0] ord, output int t_start, output int n_start,
                         output int n_ovl, output int t_rsp, output logic [2:0] s_req,
                         output logic [ID_W-1:0] s_id, output logic [QTY_W-1:0] s_qty,
                         output logic [ORD_W-1:0] s_ord);
    t_start = -1; n_start = 0; n_ovl = 0; t_rsp = -1;
    s_req = '0; s_id = '0; s_qty = '0; s_ord = '0;
    step();
    cmd_valid = 1'b1; cmd_req = req; cmd_id = id; cmd_qty = qty; cmd_order = ord;
    for (int k = 1; k <= 60 && t_rsp < 0; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      if (start_book) begin
        n_start++;
        if (is_busy) n_ovl++;
        if (t_start < 0) begin
          t_start = k; s_req = request; s_id = order_id; s_qty = quantity; s_ord = order_to_add;
        end
      end
      if (rsp_valid) t_rsp = k;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_in_n = 1'b0;
    repeat (3) step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_in_reset: got %b expected 1", cmd_ready); end
    rst_in_n = 1'b1;
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (start_book !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b expected 0", start_book); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (cnt_ok !== 16'd0) begin n_bad++; $display("FAIL reset_cnt_ok: got %0d expected 0", cnt_ok); end
    n_cmp++; if (cnt_err !== 16'd0) begin n_bad++; $display("FAIL reset_cnt_err: got %0d expected 0", cnt_err); end
    n_cmp++; if (order_to_add !== '0) begin n_bad++; $display("FAIL reset_order: got %h expected 0", order_to_add); end
    n_cmp++; if (rsp_status !== 2'd0) begin n_bad++; $display("FAIL reset_status: got %0d expected 0", rsp_status); end
  endtask

  task automatic test_add;
    int ts, ns, no, tr;
    logic [2:0] sr; logic [ID_W-1:0] si; logic [QTY_W-1:0] sq; logic [ORD_W-1:0] so;
    logic [ORD_W-1:0] ord;
    ord = {16'd100, 10'd5, 12'h064};
    busy_len = 3;
    run_cmd(3'd1, '0, '0, ord, ts, ns, no, tr, sr, si, sq, so);
    n_cmp++; if (ts !== 1) begin n_bad++; $display("FAIL add_start_cycle: got %0d expected 1", ts); end
    n_cmp++; if (ns !== 1) begin n_bad++; $display("FAIL add_start_count: got %0d expected 1", ns); end
    n_cmp++; if (so !== ord) begin n_bad++; $display("FAIL add_order_to_add: got %h expected %h", so, ord); end
    n_cmp++; if (sr !== 3'd1) begin n_bad++; $display("FAIL add_request: got %0d expected 1", sr); end
    n_cmp++; if (tr !== 7) begin n_bad++; $display("FAIL add_rsp_cycle: got %0d expected 7", tr); end
    n_cmp++; if (order_to_add !== ord) begin n_bad++; $display("FAIL add_order_stable: got %h expected %h", order_to_add, ord); end
    n_cmp++; if (rsp_status !== 2'd0) begin n_bad++; $display("FAIL add_status: got %0d expected 0", rsp_status); end
    n_cmp++; if (rsp_req !== 3'd1) begin n_bad++; $display("FAIL add_rsp_req: got %0d expected 1", rsp_req); end
    n_cmp++; if (rsp_price !== 12'h064) begin n_bad++; $display("FAIL add_price: got %h expected 064", rsp_price); end
    n_cmp++; if (rsp_price_valid !== 1'b1) begin n_bad++; $display("FAIL add_price_valid: got %b expected 1", rsp_price_valid); end
    n_cmp++; if (rsp_size !== 10'd1) begin n_bad++; $display("FAIL add_size: got %0d expected 1", rsp_size); end
    n_cmp++; if (cnt_ok !== 16'd1) begin n_bad++; $display("FAIL add_cnt_ok: got %0d expected 1", cnt_ok); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_rsp_one_cycle: got %b expected 0", rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready_after: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_bad_code;
    int ts, ns, no, tr;
    logic [2:0] sr; logic [ID_W-1:0] si; logic [QTY_W-1:0] sq; logic [ORD_W-1:0] so;
    run_cmd(3'd6, 10'd3, 16'd4, '0, ts, ns, no, tr, sr, si, sq, so);
    n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL bad_no_start: got %0d expected 0", ns); end
    n_cmp++; if (tr !== 1) begin n_bad++; $display("FAIL bad_rsp_cycle: got %0d expected 1", tr); end
    n_cmp++; if (rsp_status !== 2'd1) begin n_bad++; $display("FAIL bad_status: got %0d expected 1", rsp_status); end
    n_cmp++; if (rsp_req !== 3'd6) begin n_bad++; $display("FAIL bad_rsp_req: got %0d expected 6", rsp_req); end
    n_cmp++; if (cnt_err !== 16'd1) begin n_bad++; $display("FAIL bad_cnt_err: got %0d expected 1", cnt_err); end
    n_cmp++; if (cnt_ok !== 16'd1) begin n_bad++; $display("FAIL bad_cnt_ok: got %0d expected 1", cnt_ok); end
  endtask

  task automatic test_hold_cancel;
    int ts, ns, no, tr;
    logic [2:0] sr; logic [ID_W-1:0] si; logic [QTY_W-1:0] sq; logic [ORD_W-1:0] so;
    busy_len = 3;
    step();
    ext_len = 10;
    ext_seq++;
    run_cmd(3'd2, 10'd5, '0, '0, ts, ns, no, tr, sr, si, sq, so);
    n_cmp++; if (ts !== 11) begin n_bad++; $display("FAIL hold_start_cycle: got %0d expected 11", ts); end
    n_cmp++; if (ns !== 1) begin n_bad++; $display("FAIL hold_start_count: got %0d expected 1", ns); end
    n_cmp++; if (no !== 0) begin n_bad++; $display("FAIL hold_start_while_busy: got %0d expected 0", no); end
    n_cmp++; if (si !== 10'd5) begin n_bad++; $display("FAIL hold_order_id: got %0d expected 5", si); end
    n_cmp++; if (sr !== 3'd2) begin n_bad++; $display("FAIL hold_request: got %0d expected 2", sr); end
    n_cmp++; if (tr !== 17) begin n_bad++; $display("FAIL hold_rsp_cycle: got %0d expected 17", tr); end
    n_cmp++; if (rsp_status !== 2'd0) begin n_bad++; $display("FAIL hold_status: got %0d expected 0", rsp_status); end
    n_cmp++; if (rsp_update !== 3'b001) begin n_bad++; $display("FAIL hold_update: got %b expected 001", rsp_update); end
    n_cmp++; if (rsp_size !== 10'd0) begin n_bad++; $display("FAIL hold_size: got %0d expected 0", rsp_size); end
    n_cmp++; if (rsp_price_valid !== 1'b0) begin n_bad++; $display("FAIL hold_price_valid: got %b expected 0", rsp_price_valid); end
    n_cmp++; if (cnt_ok !== 16'd2) begin n_bad++; $display("FAIL hold_cnt_ok: got %0d expected 2", cnt_ok); end
  endtask

  task automatic test_timeout;
    int ts, ns, no, tr;
    logic [2:0] sr; logic [ID_W-1:0] si; logic [QTY_W-1:0] sq; logic [ORD_W-1:0] so;
    never_rise = 1'b1;
    run_cmd(3'd3, 10'd7, 16'd20, '0, ts, ns, no, tr, sr, si, sq, so);
    never_rise = 1'b0;
    n_cmp++; if (ts !== 1) begin n_bad++; $display("FAIL to_start_cycle: got %0d expected 1", ts); end
    n_cmp++; if (sq !== 16'd20) begin n_bad++; $display("FAIL to_quantity: got %0d expected 20", sq); end
    n_cmp++; if (tr !== 23) begin n_bad++; $display("FAIL to_rsp_cycle: got %0d expected 23", tr); end
    n_cmp++; if (rsp_status !== 2'd2) begin n_bad++; $display("FAIL to_status: got %0d expected 2", rsp_status); end
    n_cmp++; if (rsp_req !== 3'd3) begin n_bad++; $display("FAIL to_rsp_req: got %0d expected 3", rsp_req); end
    n_cmp++; if (cnt_err !== 16'd2) begin n_bad++; $display("FAIL to_cnt_err: got %0d expected 2", cnt_err); end
    n_cmp++; if (cnt_ok !== 16'd2) begin n_bad++; $display("FAIL to_cnt_ok: got %0d expected 2", cnt_ok); end
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready_after: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]        q_req [4];
    logic [ID_W-1:0]   q_id [4];
    logic [QTY_W-1:0]  q_qty [4];
    logic [ORD_W-1:0]  q_ord [4];
    logic [2:0]        e_req [4];
    logic [SIZE_W-1:0] e_size [4];
    logic [UPD_W-1:0]  e_upd [4];
    int                st_t [4];
    int                rs_t [4];
    logic [2:0]        rs_req [4];
    logic [SIZE_W-1:0] rs_size [4];
    logic [UPD_W-1:0]  rs_upd [4];
    int idx, n_st, n_rs, n_ov;
    bit adv;
    q_req[0] = 3'd1; q_id[0] = '0;     q_qty[0] = '0;     q_ord[0] = {16'd50, 10'd8, 12'h050};
    q_req[1] = 3'd1; q_id[1] = '0;     q_qty[1] = '0;     q_ord[1] = {16'd30, 10'd9, 12'h070};
    q_req[2] = 3'd3; q_id[2] = 10'd8;  q_qty[2] = 16'd10; q_ord[2] = '0;
    q_req[3] = 3'd2; q_id[3] = 10'd9;  q_qty[3] = '0;     q_ord[3] = '0;
    e_req[0] = 3'd1; e_size[0] = 10'd1; e_upd[0] = 3'b000;
    e_req[1] = 3'd1; e_size[1] = 10'd2; e_upd[1] = 3'b000;
    e_req[2] = 3'd3; e_size[2] = 10'd2; e_upd[2] = 3'b010;
    e_req[3] = 3'd2; e_size[3] = 10'd1; e_upd[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      st_t[i] = -1; rs_t[i] = -1; rs_req[i] = '0; rs_size[i] = '0; rs_upd[i] = '0;
    end
    busy_len = 2; idx = 0; n_st = 0; n_rs = 0; n_ov = 0; adv = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_req = q_req[0]; cmd_id = q_id[0]; cmd_qty = q_qty[0]; cmd_order = q_ord[0];
    for (int k = 0; k <= 80 && n_rs < 4; k++) begin
      if (k > 0) begin
        step();
        if (adv) begin
          adv = 1'b0;
          idx++;
          if (idx < 4) begin
            cmd_req = q_req[idx]; cmd_id = q_id[idx]; cmd_qty = q_qty[idx]; cmd_order = q_ord[idx];
          end else begin
            cmd_valid = 1'b0;
          end
        end
      end
      if (start_book) begin
        if (is_busy) n_ov++;
        if (n_st < 4) st_t[n_st] = k;
        n_st++;
      end
      if (rsp_valid) begin
        if (n_rs < 4) begin
          rs_t[n_rs] = k; rs_req[n_rs] = rsp_req; rs_size[n_rs] = rsp_size; rs_upd[n_rs] = rsp_update;
        end
        n_rs++;
      end
      if (cmd_valid && cmd_ready) adv = 1'b1;
    end
    cmd_valid = 1'b0;
    n_cmp++; if (n_st !== 4) begin n_bad++; $display("FAIL b2b_start_count: got %0d expected 4", n_st); end
    n_cmp++; if (n_ov !== 0) begin n_bad++; $display("FAIL b2b_start_while_busy: got %0d expected 0", n_ov); end
    n_cmp++; if (n_rs !== 4) begin n_bad++; $display("FAIL b2b_rsp_count: got %0d expected 4", n_rs); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (st_t[i] !== 1 + 7 * i) begin n_bad++; $display("FAIL b2b_start_cycle[%0d]: got %0d expected %0d", i, st_t[i], 1 + 7 * i); end
      n_cmp++; if (rs_t[i] !== 6 + 7 * i) begin n_bad++; $display("FAIL b2b_rsp_cycle[%0d]: got %0d expected %0d", i, rs_t[i], 6 + 7 * i); end
      n_cmp++; if (rs_req[i] !== e_req[i]) begin n_bad++; $display("FAIL b2b_rsp_req[%0d]: got %0d expected %0d", i, rs_req[i], e_req[i]); end
      n_cmp++; if (rs_size[i] !== e_size[i]) begin n_bad++; $display("FAIL b2b_rsp_size[%0d]: got %0d expected %0d", i, rs_size[i], e_size[i]); end
      n_cmp++; if (rs_upd[i] !== e_upd[i]) begin n_bad++; $display("FAIL b2b_rsp_update[%0d]: got %b expected %b", i, rs_upd[i], e_upd[i]); end
    end
    n_cmp++; if (rsp_price !== 12'h070) begin n_bad++; $display("FAIL b2b_price: got %h expected 070", rsp_price); end
    n_cmp++; if (cnt_ok !== 16'd6) begin n_bad++; $display("FAIL b2b_cnt_ok: got %0d expected 6", cnt_ok); end
    n_cmp++; if (cnt_err !== 16'd2) begin n_bad++; $display("FAIL b2b_cnt_err: got %0d expected 2", cnt_err); end
  endtask

  task automatic test_reset_midop;
    int n_rv, n_sb;
    logic [ORD_W-1:0] ord;
    ord = {16'd1, 10'd1, 12'h010};
    busy_len = 6;
    step();
    cmd_valid = 1'b1; cmd_req = 3'd1; cmd_id = '0; cmd_qty = '0; cmd_order = ord;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
    end
    n_cmp++; if (is_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before: got %b expected 1", is_busy); end
    rst_in_n = 1'b0;
    #1;
    n_cmp++; if (request !== 3'd0) begin n_bad++; $display("FAIL rst_mid_request: got %0d expected 0", request); end
    n_cmp++; if (order_to_add !== '0) begin n_bad++; $display("FAIL rst_mid_order: got %h expected 0", order_to_add); end
    n_cmp++; if (start_book !== 1'b0) begin n_bad++; $display("FAIL rst_mid_start: got %b expected 0", start_book); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (cnt_ok !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt_ok: got %0d expected 0", cnt_ok); end
    n_cmp++; if (cnt_err !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt_err: got %0d expected 0", cnt_err); end
    n_cmp++; if (rsp_size !== 10'd0) begin n_bad++; $display("FAIL rst_mid_rsp_size: got %0d expected 0", rsp_size); end
    n_cmp++; if (rsp_req !== 3'd0) begin n_bad++; $display("FAIL rst_mid_rsp_req: got %0d expected 0", rsp_req); end
    repeat (2) step();
    rst_in_n = 1'b1;
    n_rv = 0; n_sb = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid) n_rv++;
      if (start_book) n_sb++;
    end
    n_cmp++; if (n_rv !== 0) begin n_bad++; $display("FAIL rst_mid_no_rsp: got %0d expected 0", n_rv); end
    n_cmp++; if (n_sb !== 0) begin n_bad++; $display("FAIL rst_mid_no_start: got %0d expected 0", n_sb); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_after_reset;
    int ts, ns, no, tr;
    logic [2:0] sr; logic [ID_W-1:0] si; logic [QTY_W-1:0] sq; logic [ORD_W-1:0] so;
    busy_len = 3;
    run_cmd(3'd1, '0, '0, {16'd2, 10'd2, 12'h020}, ts, ns, no, tr, sr, si, sq, so);
    n_cmp++; if (tr !== 7) begin n_bad++; $display("FAIL post_rst_rsp_cycle: got %0d expected 7", tr); end
    n_cmp++; if (rsp_price !== 12'h020) begin n_bad++; $display("FAIL post_rst_price: got %h expected 020", rsp_price); end
    n_cmp++; if (rsp_size !== 10'd1) begin n_bad++; $display("FAIL post_rst_size: got %0d expected 1", rsp_size); end
    n_cmp++; if (cnt_ok !== 16'd1) begin n_bad++; $display("FAIL post_rst_cnt_ok: got %0d expected 1", cnt_ok); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bad_code();
    test_hold_cancel();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: got still running expected finished");
    $fatal(1, "time limit expired");
  end

endmodule
